// File: rtl/execute_stage_pkg.sv
// ---------------------------------------------------------------------------
// execute_stage_pkg
// Shared types and constants for the RV32E execute stage.
//   - alu_op_e        : 4-bit ALU opcode carried down the ID/EX register
//   - branch_cond_e   : 2-bit branch condition (BRANCH_FORCE_FALSE = 0)
//   - shift_kind_e    : direction/fill of a shift handed to the shifter
//   - shifter_state_e : iterative shifter FSM states
//   - SHIFT_STEP_DEFAULT : bits shifted per cycle by the iterative shifter
//   - shift_value()   : single shift of a word by a small amount
// ---------------------------------------------------------------------------
package execute_stage_pkg;

   localparam int SHIFT_STEP_DEFAULT = 4;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_SLL    = 4'd2,
      ALU_SRL    = 4'd3,
      ALU_SRA    = 4'd4,
      ALU_SLT    = 4'd5,
      ALU_SLTU   = 4'd6,
      ALU_XOR    = 4'd7,
      ALU_OR     = 4'd8,
      ALU_AND    = 4'd9,
      ALU_PASS_B = 4'd10
   } alu_op_e;

   typedef enum logic [1:0] {
      BRANCH_FORCE_FALSE = 2'd0,
      BRANCH_FORCE_TRUE  = 2'd1,
      BRANCH_ZERO        = 2'd2,
      BRANCH_NONZERO     = 2'd3
   } branch_cond_e;

   typedef enum logic [1:0] {
      SHIFT_LEFT          = 2'd0,
      SHIFT_RIGHT_LOGICAL = 2'd1,
      SHIFT_RIGHT_ARITH   = 2'd2
   } shift_kind_e;

   typedef enum logic {
      SHIFTER_IDLE = 1'b0,
      SHIFTER_BUSY = 1'b1
   } shifter_state_e;

   // Arithmetic right shifts replicate bit 31 of the word being shifted, so
   // repeatedly shifting a partial result keeps the original sign fill.
   function automatic logic [31:0] shift_value(shift_kind_e kind,
                                               logic [31:0] value,
                                               logic [5:0]  amount);
      logic [31:0] shifted;
      case (kind)
         SHIFT_LEFT:          shifted = value << amount;
         SHIFT_RIGHT_LOGICAL: shifted = value >> amount;
         default:             shifted = $unsigned($signed(value) >>> amount);
      endcase
      return shifted;
   endfunction

endpackage

// File: rtl/execute_stage_shifter.sv
// ---------------------------------------------------------------------------
// iterative_shifter
// Multi-cycle shifter for the execute stage. Shifts of up to SHIFT_STEP bits
// finish combinationally; longer shifts walk through an accumulator
// SHIFT_STEP bits per cycle while stall is raised.
// Ports:
//   clk, rst : pipeline clock, asynchronous active-high reset
//   start    : a valid shift instruction is presented this cycle
//   flush    : EX slot is invalid; abandons a shift in progress
//   kind     : shift direction / fill
//   value    : operand to shift
//   shamt    : shift amount
//   result   : shifted word (meaningful when stall is low)
//   busy     : a long shift is in progress (accumulator owns the result)
//   stall    : hold upstream stages, more cycles are needed
// ---------------------------------------------------------------------------
module iterative_shifter
   import execute_stage_pkg::*;
#(
   parameter int SHIFT_STEP = SHIFT_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        flush,
   input  shift_kind_e kind,
   input  logic [31:0] value,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        busy,
   output logic        stall
);

   // Width able to hold 0..SHIFT_STEP; the final shifter only ever needs
   // that range, so masking the amount keeps it a narrow barrel.
   localparam int         AW       = $clog2(SHIFT_STEP) + 1;
   localparam logic [5:0] STEP6    = 6'(SHIFT_STEP);
   localparam logic [4:0] STEP5    = 5'(SHIFT_STEP);
   localparam logic [5:0] AMT_MASK = 6'((1 << AW) - 1);

   shifter_state_e state;
   logic [31:0]    acc;
   logic [4:0]     remaining;
   shift_kind_e    kind_q;
   logic           long_shift;
   logic           more_steps;

   assign long_shift = {1'b0, shamt} > STEP6;
   assign more_steps = {1'b0, remaining} > STEP6;
   assign busy       = (state == SHIFTER_BUSY);

   // FSM and accumulator. The operation kind is captured at start so that
   // the walk does not depend on upstream inputs once it is under way.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SHIFTER_IDLE;
         acc       <= '0;
         remaining <= '0;
         kind_q    <= SHIFT_LEFT;
      end else begin
         case (state)
            SHIFTER_IDLE: begin
               if (start && long_shift) begin
                  state     <= SHIFTER_BUSY;
                  acc       <= shift_value(kind, value, STEP6);
                  remaining <= shamt - STEP5;
                  kind_q    <= kind;
               end
            end
            default: begin
               if (flush) begin
                  state <= SHIFTER_IDLE;
               end else if (more_steps) begin
                  acc       <= shift_value(kind_q, acc, STEP6);
                  remaining <= remaining - STEP5;
               end else begin
                  state <= SHIFTER_IDLE;
               end
            end
         endcase
      end
   end

   // Stall covers the first presentation cycle and every BUSY cycle that
   // still has more than one step left; a flush drops it immediately.
   always_comb begin
      stall = 1'b0;
      if (!rst) begin
         if (state == SHIFTER_IDLE)
            stall = start && long_shift;
         else
            stall = !flush && more_steps;
      end
   end

   // Final (or only) partial shift, at most SHIFT_STEP bits.
   always_comb begin
      if (state == SHIFTER_BUSY)
         result = shift_value(kind_q, acc, {1'b0, remaining} & AMT_MASK);
      else
         result = shift_value(kind, value, {1'b0, shamt} & AMT_MASK);
   end

endmodule

// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
// EX stage of the RV32E pipeline: operand selection, ALU, branch/jump
// resolution and redirect target generation. Long shifts use an iterative
// shifter that stalls the front of the pipeline.
// Ports:
//   clk, rst            : pipeline clock, asynchronous active-high reset
//   invalid_EX          : EX slot holds a bubble / flushed instruction
//   pc0_EX, pc4_EX      : PC and PC+4 of the instruction
//   alu_operation_EX    : ALU opcode (alu_op_e)
//   alu_a_sel_EX        : 0 = rs1_data, 1 = pc0
//   alu_b_sel_EX        : 0 = rs2_data, 1 = immediate
//   immediate_EX        : sign-extended immediate
//   rs1_data_EX, rs2_data_EX : register operands
//   branch_condition_EX : branch_cond_e
//   branch_base_sel_EX  : 0 = pc0, 1 = rs1_data (JALR)
//   alu_result          : ALU result
//   branch_taken        : redirect the PC this cycle
//   branch_target       : redirect address
//   stall_EX            : multi-cycle op in progress, hold IF/ID/EX
// ---------------------------------------------------------------------------
module execute_stage
   import execute_stage_pkg::*;
#(
   parameter int SHIFT_STEP = SHIFT_STEP_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        invalid_EX,
   input  logic [31:0] pc0_EX,
   input  logic [31:0] pc4_EX,
   input  logic [3:0]  alu_operation_EX,
   input  logic        alu_a_sel_EX,
   input  logic        alu_b_sel_EX,
   input  logic [31:0] immediate_EX,
   input  logic [31:0] rs1_data_EX,
   input  logic [31:0] rs2_data_EX,
   input  logic [1:0]  branch_condition_EX,
   input  logic        branch_base_sel_EX,
   output logic [31:0] alu_result,
   output logic        branch_taken,
   output logic [31:0] branch_target,
   output logic        stall_EX
);

   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        is_shift;
   shift_kind_e shift_kind;
   logic [31:0] shift_result;
   logic        shift_busy;
   logic        cond_met;
   logic [31:0] branch_base;
   logic [31:0] target_sum;
   logic        unused_pc4;

   // PC+4 is carried alongside in the pipeline but not consumed here.
   assign unused_pc4 = ^pc4_EX;

   assign op_a = alu_a_sel_EX ? pc0_EX : rs1_data_EX;
   assign op_b = alu_b_sel_EX ? immediate_EX : rs2_data_EX;

   // Classify shift opcodes for the iterative shifter.
   always_comb begin
      is_shift   = 1'b0;
      shift_kind = SHIFT_LEFT;
      case (alu_op_e'(alu_operation_EX))
         ALU_SLL: begin
            is_shift   = 1'b1;
            shift_kind = SHIFT_LEFT;
         end
         ALU_SRL: begin
            is_shift   = 1'b1;
            shift_kind = SHIFT_RIGHT_LOGICAL;
         end
         ALU_SRA: begin
            is_shift   = 1'b1;
            shift_kind = SHIFT_RIGHT_ARITH;
         end
         default: ;
      endcase
   end

   iterative_shifter #(
      .SHIFT_STEP(SHIFT_STEP)
   ) u_shifter (
      .clk    (clk),
      .rst    (rst),
      .start  (is_shift && !invalid_EX),
      .flush  (invalid_EX),
      .kind   (shift_kind),
      .value  (op_a),
      .shamt  (op_b[4:0]),
      .result (shift_result),
      .busy   (shift_busy),
      .stall  (stall_EX)
   );

   // ALU. While a long shift is walking, the accumulator owns the result
   // regardless of what the opcode lines show.
   always_comb begin
      alu_result = '0;
      if (shift_busy) begin
         alu_result = shift_result;
      end else begin
         case (alu_op_e'(alu_operation_EX))
            ALU_ADD:    alu_result = op_a + op_b;
            ALU_SUB:    alu_result = op_a - op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:    alu_result = shift_result;
            ALU_SLT:    alu_result = {31'b0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU:   alu_result = {31'b0, op_a < op_b};
            ALU_XOR:    alu_result = op_a ^ op_b;
            ALU_OR:     alu_result = op_a | op_b;
            ALU_AND:    alu_result = op_a & op_b;
            ALU_PASS_B: alu_result = op_b;
            default:    alu_result = '0;
         endcase
      end
   end

   // Branch condition evaluated on the ALU result (SUB for BEQ/BNE, SLT/SLTU
   // for the ordered compares).
   always_comb begin
      cond_met = 1'b0;
      case (branch_cond_e'(branch_condition_EX))
         BRANCH_FORCE_FALSE: cond_met = 1'b0;
         BRANCH_FORCE_TRUE:  cond_met = 1'b1;
         BRANCH_ZERO:        cond_met = (alu_result == 32'd0);
         BRANCH_NONZERO:     cond_met = (alu_result != 32'd0);
         default:            cond_met = 1'b0;
      endcase
   end

   assign branch_taken = cond_met && !invalid_EX && !stall_EX && !rst;

   // JALR targets drop bit 0; PC-relative targets are used as computed.
   assign branch_base   = branch_base_sel_EX ? rs1_data_EX : pc0_EX;
   assign target_sum    = branch_base + immediate_EX;
   assign branch_target = {target_sum[31:1], target_sum[0] & ~branch_base_sel_EX};

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the RV32E pipeline. Consumes the ID/EX pipeline register outputs and performs ALU operand selection, ALU evaluation, branch/jump resolution and target generation.
- Shifts run on an iterative multi-cycle shifter. It raises stall_EX, which freezes IF/ID/EX until the shift completes.
- Results feed the EX/MEM register and the PC redirect logic.

Parameters:
SHIFT_STEP, 4, bits shifted per cycle; power of 2 in 1..32; 32 disables multi-cycle shifting (stall_EX never asserts).

Ports:
clk  input  1  pipeline clock
rst  input  1  asynchronous reset, active-high
invalid_EX  input  1  EX slot holds a bubble/flushed instruction
pc0_EX  input  32  PC of instruction
pc4_EX  input  32  PC+4, passed through
alu_operation_EX  input  4  ALU opcode (package enum)
alu_a_sel_EX  input  1  0 = rs1_data, 1 = pc0
alu_b_sel_EX  input  1  0 = rs2_data, 1 = immediate
immediate_EX  input  32  sign-extended immediate
rs1_data_EX  input  32  register operand 1
rs2_data_EX  input  32  register operand 2
branch_condition_EX  input  2  FORCE_FALSE/FORCE_TRUE/ZERO/NONZERO
branch_base_sel_EX  input  1  0 = pc0, 1 = rs1_data (JALR)
alu_result  output  32  ALU result
branch_taken  output  1  redirect PC this cycle
branch_target  output  32  redirect address
stall_EX  output  1  multi-cycle op in progress; hold upstream stages

Behaviour:
- Operands: a = alu_a_sel ? pc0 : rs1. b = alu_b_sel ? imm : rs2.
- Ops, all 32-bit, wrap-around arithmetic: ADD, SUB, SLL, SRL, SRA, SLT (signed), SLTU, XOR, OR, AND, PASS_B (LUI). Undefined opcodes yield 0.
- Shift amount = b[4:0].
- Branch condition:
  - FORCE_FALSE -> taken 0.
  - FORCE_TRUE -> 1.
  - ZERO -> alu_result == 0.
  - NONZERO -> alu_result != 0.
  - BEQ/BNE use SUB; BLT/BGE use SLT; BLTU/BGEU use SLTU.
- branch_taken is forced 0 when invalid_EX=1, when stall_EX=1, or while rst=1.
- branch_target = (base + imm). When branch_base_sel=1, bit 0 is cleared. Computed every cycle regardless of taken.
- Non-shift ops and shifts with shamt <= SHIFT_STEP: combinational, 0 extra cycles, stall_EX=0.
- Shifts with shamt > SHIFT_STEP, N = ceil(shamt/SHIFT_STEP):
  - FSM states IDLE, BUSY.
  - IDLE->BUSY on a valid long shift. At that edge, register acc = a shifted by SHIFT_STEP and remaining = shamt - SHIFT_STEP.
  - BUSY:
    - If remaining > SHIFT_STEP: acc shifts by SHIFT_STEP, remaining -= SHIFT_STEP.
    - Else: alu_result = acc shifted by remaining (combinational), stall_EX=0, and the next state is IDLE.
  - stall_EX is high combinationally for exactly N-1 consecutive cycles, starting in the cycle the shift is first presented. The final result is valid in cycle N with stall_EX low.
  - SRA fills with the original sign bit throughout.
- Inputs are held stable by the upstream stall; the FSM ignores input changes while BUSY except invalid_EX.
- invalid_EX=1 while BUSY (flush):
  - stall_EX drops the same cycle.
  - FSM returns to IDLE at the next edge; acc contents are discarded.
- invalid_EX=1 in IDLE: no shift starts, stall_EX=0.
- Reset (async, any time including mid-shift):
  - state IDLE, acc 0, remaining 0.
  - stall_EX=0 and branch_taken=0 while rst is high.
  - alu_result and branch_target stay combinational functions of the inputs.
- Back-to-back long shifts: a second shift presented in the cycle after completion starts normally from IDLE.

Decomposition:
- Shared package (alongside the existing defines): ALU opcode enum (4-bit), branch condition enum (2-bit, FORCE_FALSE = the existing BRANCH_FORCE_FALSE encoding), SHIFT_STEP default constant.
- Sub-module iterative_shifter: the FSM, acc and remaining registers, and the stall generation.
- ALU mux, compare and branch logic stay in execute_stage.

Test Plan:
- ADD, alu_a_sel=0/b_sel=0, rs1=5, rs2=7 -> alu_result=12, stall_EX=0, branch_taken=0 (FORCE_FALSE).
- SLL, a=1, b=13, STEP=4 -> stall_EX high 3 cycles, alu_result=0x00002000 in cycle 4 with stall_EX=0.
- SRA, a=0x80000000, b=31 -> stall_EX high 7 cycles, result 0xFFFFFFFF in cycle 8. Repeat with SRL -> 0x00000001.
- BEQ: SUB, rs1=rs2=9, ZERO, pc0=0x100, imm=-8 -> branch_taken=1, target=0x000000F8. Same with rs2=10 -> taken=0.
- JALR: FORCE_TRUE, base_sel=1, rs1=0x203, imm=4 -> target=0x206, taken=1. Same with invalid_EX=1 -> taken=0.
- Abort and reset mid-shift:
  - SLL by 20, invalid_EX asserted in cycle 2 -> stall_EX=0 that cycle; next ADD 1+1 completes with result 2 and no stall.
  - Repeat with rst pulsed mid-shift -> stall_EX=0 immediately; FSM starts IDLE after release.
